// File: rtl/gate_deadtime_ctrl.sv
// gate_deadtime_ctrl: complementary half-bridge gate commands with dead time from comparator results
// Ports: clk, rst (async, active-low), en (0 clears everything), cmp_valid (step tick),
//   cmp_gt/cmp_lt (comparator agb/alb), gate_hi/gate_lo (state-decoded gates),
//   fault (sticky illegal code), switch_cnt (gate turn-on count, wraps),
//   done_sig (cmp_valid delayed one clock, aligned with gate update).
module gate_deadtime_ctrl #(
  parameter int DEAD_STEPS = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmp_valid,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             gate_hi,
  output logic             gate_lo,
  output logic             fault,
  output logic [CNT_W-1:0] switch_cnt,
  output logic             done_sig
);
  typedef enum logic [2:0] {OFF, DT_HI, HI, DT_LO, LO, FLT} state_t;
  typedef enum logic [1:0] {C_NONE, C_HI, C_LO} cmd_t;
  localparam logic [7:0] DT_LOAD = DEAD_STEPS == 0 ? 8'd0 : 8'(DEAD_STEPS - 1);
  state_t state, state_n, tgt, dtst;
  cmd_t prev, prev_n, cmd;
  logic [7:0] dt, dt_n;
  logic fault_n, ill;
  logic [CNT_W-1:0] cnt_n;
  assign ill = cmp_gt & cmp_lt;
  // no-code ticks repeat the last legal command, so dead time keeps counting down
  assign cmd = cmp_gt & ~cmp_lt ? C_HI : cmp_lt & ~cmp_gt ? C_LO : prev;
  assign tgt = cmd == C_HI ? HI : LO;
  assign dtst = cmd == C_HI ? DT_HI : DT_LO;
  always_comb begin
    state_n = state;
    dt_n = dt;
    prev_n = prev;
    fault_n = fault;
    cnt_n = switch_cnt;
    if (!en) begin
      state_n = OFF;
      dt_n = '0;
      prev_n = C_NONE;
      fault_n = 1'b0;
      cnt_n = '0;
    end else if (cmp_valid) begin
      prev_n = ill ? prev : cmd;
      if (ill || state == FLT) begin
        state_n = FLT;
        fault_n = 1'b1;
      end else if (cmd != C_NONE && state != tgt) begin
        if (state == dtst) begin
          state_n = dt == 8'd0 ? tgt : state;
          dt_n = dt == 8'd0 ? dt : dt - 8'd1;
          cnt_n = dt == 8'd0 ? switch_cnt + 1'b1 : switch_cnt;
        end else if (DEAD_STEPS == 0) begin
          state_n = tgt;
          cnt_n = switch_cnt + 1'b1;
        end else begin
          // entering or reversing inside dead time restarts the count
          state_n = dtst;
          dt_n = DT_LOAD;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= OFF;
      dt <= '0;
      prev <= C_NONE;
      fault <= 1'b0;
      switch_cnt <= '0;
      done_sig <= 1'b0;
    end else begin
      state <= state_n;
      dt <= dt_n;
      prev <= prev_n;
      fault <= fault_n;
      switch_cnt <= cnt_n;
      done_sig <= cmp_valid;
    end
  end
  assign gate_hi = state == HI;
  assign gate_lo = state == LO;
endmodule

// File: tb/tb_gate_deadtime_ctrl.sv
// tb_gate_deadtime_ctrl: directed vector bench for gate_deadtime_ctrl
module tb_gate_deadtime_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic en0 = 1'b0, v0 = 1'b0, gt0 = 1'b0, lt0 = 1'b0;
  logic en1 = 1'b0, v1 = 1'b0, gt1 = 1'b0, lt1 = 1'b0;
  logic hi0, lo0, f0, d0, hi1, lo1, f1, d1;
  logic [15:0] c0, c1;
  int total = 0;
  int bad = 0;
  gate_deadtime_ctrl #(.DEAD_STEPS(2), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .en(en0), .cmp_valid(v0), .cmp_gt(gt0), .cmp_lt(lt0),
    .gate_hi(hi0), .gate_lo(lo0), .fault(f0), .switch_cnt(c0), .done_sig(d0)
  );
  gate_deadtime_ctrl #(.DEAD_STEPS(0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .en(en1), .cmp_valid(v1), .cmp_gt(gt1), .cmp_lt(lt1),
    .gate_hi(hi1), .gate_lo(lo1), .fault(f1), .switch_cnt(c1), .done_sig(d1)
  );
  typedef struct {
    logic en, v, gt, lt, hi, lo, f;
    logic [15:0] cnt;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic step1(input logic gt, input logic lt, input logic hi, input logic lo, input logic [15:0] cnt, input string name);
    @(negedge clk);
    {en1, v1, gt1, lt1} = {1'b1, 1'b1, gt, lt};
    @(posedge clk);
    #1;
    chk({name, "_hi"}, 32'(hi1), 32'(hi));
    chk({name, "_lo"}, 32'(lo1), 32'(lo));
    chk({name, "_cnt"}, 32'(c1), 32'(cnt));
  endtask
  initial begin
    //           en   v    gt   lt   hi   lo   f    cnt
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1});
    // reset held with random inputs on both instances
    repeat (3) begin
      @(negedge clk);
      {en0, v0, gt0, lt0} = 4'($urandom);
      {en1, v1, gt1, lt1} = 4'($urandom);
      v0 = 1'b1;
    end
    #1;
    chk("rst_gates0", {hi0, lo0}, 0);
    chk("rst_fault0", 32'(f0), 0);
    chk("rst_cnt0", 32'(c0), 0);
    chk("rst_done0", 32'(d0), 0);
    chk("rst_all1", {hi1, lo1, f1, d1, c1}, 0);
    @(negedge clk);
    {en0, v0, gt0, lt0} = 4'b0000;
    {en1, v1, gt1, lt1} = 4'b0000;
    rst = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      {en0, v0, gt0, lt0} = {tbl[i].en, tbl[i].v, tbl[i].gt, tbl[i].lt};
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_hi", i), 32'(hi0), 32'(tbl[i].hi));
      chk($sformatf("vec%0d_lo", i), 32'(lo0), 32'(tbl[i].lo));
      chk($sformatf("vec%0d_fault", i), 32'(f0), 32'(tbl[i].f));
      chk($sformatf("vec%0d_cnt", i), 32'(c0), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_done", i), 32'(d0), 32'(tbl[i].v));
      chk($sformatf("vec%0d_excl", i), 32'(hi0 & lo0), 0);
    end
    // asynchronous reset lands between edges
    #2;
    rst = 1'b0;
    #1;
    chk("async_gates", {hi0, lo0}, 0);
    chk("async_cnt", 32'(c0), 0);
    @(negedge clk);
    rst = 1'b1;
    {en0, v0, gt0, lt0} = 4'b0000;
    // zero dead time: immediate switching, then counter wrap
    step1(1'b1, 1'b0, 1'b1, 1'b0, 16'd1, "dt0_hi");
    step1(1'b0, 1'b1, 1'b0, 1'b1, 16'd2, "dt0_lo");
    for (int i = 0; i < 65533; i++) begin
      @(negedge clk);
      gt1 = (i % 2) == 0;
      lt1 = ~gt1;
    end
    @(posedge clk);
    #1;
    chk("wrap_pre_cnt", 32'(c1), 32'h0000FFFF);
    chk("wrap_pre_hi", 32'(hi1), 1);
    step1(1'b0, 1'b1, 1'b0, 1'b1, 16'd0, "wrap");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
